// File: rtl/rc4_swap_engine_pkg.sv
// Shared types and constants for the nibble-RC4 swap engine.
package rc4_pkg;
  localparam int SYM_W    = 4;
  localparam int N_SYM    = 16;
  localparam int DROP_CNT = 16;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    KSA,
    PRGA
  } state_t;

  typedef struct packed {
    logic wr;
    sym_t a1;
    sym_t d1;
    sym_t a2;
    sym_t d2;
  } mir_t;
endpackage

// File: rtl/rc4_swap_engine_if.sv
// Keystream handshake plus S-box mirror write port.
interface rc4_swap_engine_if;
  import rc4_pkg::*;

  sym_t ks_data;
  logic ks_valid;
  logic ks_ready;
  logic mir_wr;
  sym_t mir_a1;
  sym_t mir_d1;
  sym_t mir_a2;
  sym_t mir_d2;

  modport master (
    output ks_data, ks_valid,
    output mir_wr, mir_a1, mir_d1,
    output mir_a2, mir_d2,
    input  ks_ready
  );

  modport slave (
    input  ks_data, ks_valid,
    input  mir_wr, mir_a1, mir_d1,
    input  mir_a2, mir_d2,
    output ks_ready
  );
endinterface

// File: rtl/rc4_swap_engine_sbox_regs.sv
// 16x4 working S-box: combinational reads, dual write
// (write 2 wins on an address collision).
module rc4_sbox_regs
  import rc4_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  sym_t ra1,
  input  sym_t ra2,
  input  sym_t ra3,
  output sym_t rd1,
  output sym_t rd2,
  output sym_t rd3,
  input  logic we,
  input  sym_t wa1,
  input  sym_t wd1,
  input  sym_t wa2,
  input  sym_t wd2
);
  sym_t s [N_SYM];

  assign rd1 = s[ra1];
  assign rd2 = s[ra2];
  assign rd3 = s[ra3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SYM; k++)
        s[k] <= '0;
    end else if (we) begin
      s[wa1] <= wd1;
      s[wa2] <= wd2;
    end
  end
endmodule

// File: rtl/rc4_swap_engine.sv
// Nibble-RC4 INIT/KSA/PRGA sequencer with mirrored swaps.
// RC4_DROP_EN: discard the first DROP_CNT keystream nibbles.
module rc4_swap_engine
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*KEY_LEN-1:0] key,
  input  logic                 stop,
  output logic                 busy,
  rc4_swap_engine_if.master    ks
);
  state_t state_q, state_d;
  sym_t i_q, i_d, j_q, j_d;
  sym_t ksd_q, ksd_d;
  logic ksv_q, ksv_d;
  logic busy_q, busy_d;
  logic [4*KEY_LEN-1:0] key_q, key_d;

  sym_t in_idx, ra1, rd1, rd2, rd3;
  sym_t jn, t, k_nib, sel;
  logic fire, dropping;
  mir_t m;

`ifdef RC4_DROP_EN
  logic [4:0] drop_q, drop_d;
  assign dropping = (drop_q < 5'(DROP_CNT));
`else
  assign dropping = 1'b0;
`endif

  assign k_nib  = key_q[4*(int'(i_q) % KEY_LEN) +: 4];
  assign in_idx = i_q + 4'd1;
  assign ra1    = (state_q == PRGA) ? in_idx : i_q;
  assign jn     = j_q + rd1 + ((state_q == KSA) ? k_nib : 4'd0);
  assign t      = rd1 + rd2;
  // Output is post-swap S[t]: the two swapped slots come from the old reads.
  assign sel    = (t == in_idx) ? rd2 :
                  (t == jn)     ? rd1 : rd3;
  assign fire   = !ksv_q || ks.ks_ready;

  rc4_sbox_regs u_sbox (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ra1),
    .ra2   (jn),
    .ra3   (t),
    .rd1   (rd1),
    .rd2   (rd2),
    .rd3   (rd3),
    .we    (m.wr),
    .wa1   (m.a1),
    .wd1   (m.d1),
    .wa2   (m.a2),
    .wd2   (m.d2)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    key_d   = key_q;
    ksv_d   = ksv_q;
    ksd_d   = ksd_q;
    m       = '0;
`ifdef RC4_DROP_EN
    drop_d  = drop_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          i_d     = '0;
          j_d     = '0;
          key_d   = key;
`ifdef RC4_DROP_EN
          drop_d  = '0;
`endif
        end
      end
      INIT: begin
        m   = '{wr: 1'b1, a1: i_q, d1: i_q, a2: i_q, d2: i_q};
        i_d = i_q + 4'd1;
        if (i_q == 4'd15)
          state_d = KSA;
      end
      KSA: begin
        m   = '{wr: 1'b1, a1: i_q, d1: rd2, a2: jn, d2: rd1};
        i_d = i_q + 4'd1;
        j_d = jn;
        if (i_q == 4'd15) begin
          state_d = PRGA;
          j_d     = '0;
        end
      end
      PRGA: begin
        if (fire) begin
          m     = '{wr: 1'b1, a1: in_idx, d1: rd2, a2: jn, d2: rd1};
          i_d   = in_idx;
          j_d   = jn;
          ksv_d = !dropping;
          if (!dropping)
            ksd_d = sel;
`ifdef RC4_DROP_EN
          if (dropping)
            drop_d = drop_q + 5'd1;
`endif
        end
      end
    endcase
    if (stop) begin
      state_d = IDLE;
      i_d     = '0;
      j_d     = '0;
      ksv_d   = 1'b0;
      m       = '0;
    end
    busy_d = ((state_q == INIT) || (state_q == KSA)) && !stop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      key_q   <= '0;
      ksv_q   <= 1'b0;
      ksd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      key_q   <= key_d;
      ksv_q   <= ksv_d;
      ksd_q   <= ksd_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RC4_DROP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_q <= '0;
    else
      drop_q <= drop_d;
  end
`endif

  assign busy        = busy_q;
  assign ks.ks_data  = ksd_q;
  assign ks.ks_valid = ksv_q;
  assign ks.mir_wr   = m.wr;
  assign ks.mir_a1   = m.a1;
  assign ks.mir_d1   = m.d1;
  assign ks.mir_a2   = m.a2;
  assign ks.mir_d2   = m.d2;
endmodule

// File: tb/tb_rc4_swap_engine.sv
// Directed/randomised bench for rc4_swap_engine against a
// textbook nibble-RC4 reference model.
module tb_rc4_swap_engine;
  localparam int KL   = 4;
  localparam int NOUT = 64;
`ifdef RC4_DROP_EN
  localparam int DROP = 16;
`else
  localparam int DROP = 0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        busy;
  logic [15:0] key   = '0;

  rc4_swap_engine_if bus ();

  rc4_swap_engine #(.KEY_LEN(KL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .key   (key),
    .stop  (stop),
    .busy  (busy),
    .ks    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;
  int rx          = 0;
  int psteps      = 0;
  bit act         = 1'b0;

  logic [3:0]  copy   [16];
  logic [63:0] snap   [NOUT+DROP+1];
  logic [3:0]  ks_exp [NOUT];
  logic [15:0] rkey;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int s [16]);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < 16; c++)
      r[4*c +: 4] = 4'(s[c]);
    return r;
  endfunction

  function automatic logic [63:0] pkc();
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < 16; c++)
      r[4*c +: 4] = copy[c];
    return r;
  endfunction

  // Plain RC4 over Z/16: KSA, then PRGA keystream and S snapshots.
  task automatic model_build(input logic [15:0] k);
    int s [16];
    int i, j, tmp;
    for (int c = 0; c < 16; c++) s[c] = c;
    j = 0;
    for (int c = 0; c < 16; c++) begin
      j = (j + s[c] + int'(k[4*(c % KL) +: 4])) % 16;
      tmp = s[c]; s[c] = s[j]; s[j] = tmp;
    end
    snap[0] = pk(s);
    i = 0;
    j = 0;
    for (int n = 0; n < NOUT + DROP; n++) begin
      i = (i + 1) % 16;
      j = (j + s[i]) % 16;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      snap[n+1] = pk(s);
      if (n >= DROP)
        ks_exp[n-DROP] = 4'(s[(s[i] + s[j]) % 16]);
    end
  endtask

  task automatic step();
    logic [3:0] c;
    #1;
    c = 4'(edge_n);
    if (bus.mir_wr) begin
      copy[bus.mir_a1] = bus.mir_d1;
      copy[bus.mir_a2] = bus.mir_d2;
    end
    if (act) begin
      if (edge_n >= 0 && edge_n < 16)
        chk("init_mirror",
            {bus.mir_wr, bus.mir_a1, bus.mir_d1, bus.mir_a2, bus.mir_d2},
            {1'b1, c, c, c, c});
      if (edge_n >= 32) begin
        chk("prga_mir_wr", bus.mir_wr, !bus.ks_valid || bus.ks_ready);
        if (bus.mir_wr) psteps++;
      end
      if ((edge_n == 31 || (edge_n >= 32 && bus.mir_wr)) &&
          psteps <= NOUT + DROP)
        chk("mirror_copy", pkc(), snap[psteps]);
      if (bus.ks_valid && rx < NOUT) begin
        chk("ks_data", bus.ks_data, ks_exp[rx]);
        if (bus.ks_ready) rx++;
      end
    end
    @(posedge clk);
    #1;
    edge_n++;
    if (act)
      chk("busy", busy, edge_n >= 1 && edge_n <= 32);
  endtask

  task automatic run_start(input logic [15:0] k);
    model_build(k);
    key    = k;
    start  = 1'b1;
    edge_n = -1;
    rx     = 0;
    psteps = 0;
    act    = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.ks_valid && n < 120) begin
      step();
      n++;
    end
    chk("first_valid_edge", edge_n, 33 + DROP);
    chk("first_valid", bus.ks_valid, 1);
  endtask

  task automatic consume(input int n, input int pct);
    int b;
    b = 0;
    while (rx < n && b < 400) begin
      bus.ks_ready = ($urandom_range(0, 99) >= pct);
      step();
      b++;
    end
    chk("consume_count", rx, n);
    bus.ks_ready = 1'b1;
  endtask

  task automatic stop_engine();
    act          = 1'b0;
    bus.ks_ready = 1'b1;
    stop         = 1'b1;
    #1;
    chk("stop_mir_wr", bus.mir_wr, 0);
    @(posedge clk);
    #1;
    stop = 1'b0;
    chk("stop_valid", bus.ks_valid, 0);
    chk("stop_busy", busy, 0);
    repeat (3) step();
    chk("idle_after_stop", {bus.ks_valid, bus.mir_wr, busy}, 0);
  endtask

  initial begin
    bus.ks_ready = 1'b1;
    #12;
    chk("reset_outputs",
        {busy, bus.ks_valid, bus.ks_data, bus.mir_wr,
         bus.mir_a1, bus.mir_d1, bus.mir_a2, bus.mir_d2}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Key 0, with a stray start pulse during INIT.
    run_start(16'h0000);
    repeat (3) step();
    key   = 16'($urandom);
    start = 1'b1;
    step();
    start = 1'b0;
    while (edge_n < 32) step();
    chk("ksa_sbox_key0", pkc(), 64'hA4B7_CD5F_8129_E360);
    wait_valid();
`ifndef RC4_DROP_EN
    chk("first_ks_key0", bus.ks_data, 8);
`endif
    bus.ks_ready = 1'b0;
    repeat (5) step();
    chk("hold_data", bus.ks_data, ks_exp[0]);
    bus.ks_ready = 1'b1;
    step();
    chk("after_release", bus.ks_data, ks_exp[1]);
`ifndef RC4_DROP_EN
    chk("second_ks_key0", bus.ks_data, 15);
`endif
    consume(30, 30);
    stop_engine();

    // Random key with random backpressure.
    run_start(16'($urandom));
    wait_valid();
    consume(40, 50);
    stop_engine();

    // Async reset mid-KSA, then an identical rerun.
    rkey = 16'($urandom);
    run_start(rkey);
    while (edge_n < 19) step();
    act = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_ksa",
        {busy, bus.ks_valid, bus.ks_data, bus.mir_wr,
         bus.mir_a1, bus.mir_d1, bus.mir_a2, bus.mir_d2}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step();
    chk("idle_after_reset", {bus.ks_valid, bus.mir_wr, busy}, 0);
    run_start(rkey);
    wait_valid();
    consume(20, 25);
    stop_engine();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
